local_gau_weighter: RTL and testbench
=====================================

Name: local_gau_weighter

Overview:
- Consumer side of the 16x16 local Gaussian weight ROM used for SIFT descriptor generation.
- Accepts a raster-ordered stream of 256 gradient samples (magnitude + orientation bin) for one keypoint window.
- Drives the ROM address in lockstep with the sample index and multiplies each magnitude by the returned weight.
- Emits a weighted, scaled and saturated stream to the histogram accumulator under valid/ready handshakes.

Parameters:
- MAG_W, 16, input gradient magnitude width (unsigned).
- ORI_W, 3, orientation bin width; passed through unchanged.
- OUT_W, 16, weighted magnitude output width (unsigned).
- SHIFT, 4, right shift applied to the product (mag*weight) before saturation.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle pulse; begins a 256-sample window; honoured only in IDLE.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input sample accepted when in_valid&&in_ready.
- in_mag  in  MAG_W  gradient magnitude.
- in_ori  in  ORI_W  orientation bin.
- rom_addr  out  8  address to the weight ROM; equals current sample index {row[3:0],col[3:0]}.
- rom_data  in  8  weight from the ROM; combinational, valid in the same cycle as rom_addr.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream ready.
- out_wmag  out  OUT_W  weighted magnitude.
- out_ori  out  ORI_W  registered copy of in_ori.
- out_idx  out  8  sample index of the output (row*16+col).
- out_last  out  1  high with the sample at index 255.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the last sample is consumed downstream.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, idx=0, rom_addr=0, in_ready=0, out_valid=0, out_wmag=0, out_ori=0, out_idx=0, out_last=0, busy=0, done=0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: start -> RUN with idx=0. start during RUN or DRAIN is ignored.
  - RUN: each accepted input increments idx, 8-bit, no wrap used. Acceptance at idx=255 -> DRAIN.
  - DRAIN: the output register holds sample 255. When out_valid&&out_ready, done=1 for one cycle, then -> IDLE with idx=0.
- rom_addr = idx, combinational from the idx register, so the ROM lookup adds no latency.
- in_ready = (state==RUN) && (!out_valid || out_ready). In IDLE and DRAIN, in_ready=0.
- Pipeline: one register stage, latency 1 cycle from input acceptance to out_valid.
- Datapath on acceptance:
  - prod = in_mag * rom_data, MAG_W+8 bits, unsigned.
  - scaled = prod >> SHIFT.
  - out_wmag = (scaled > 2^OUT_W-1) ? all-ones : scaled[OUT_W-1:0].
  - out_ori = in_ori, out_idx = idx, out_last = (idx==255).
- Output hold rule: out_valid&&!out_ready holds every out_* stable and blocks input (in_ready=0).
- out_valid clears on out_valid&&out_ready when no new input is accepted in the same cycle. Simultaneous output consume and input accept reloads the register, so throughput is 1 sample/clk.
- Weight 0, at indices 0, 15, 240 and 255, produces out_wmag=0 but still emits a valid sample.
- rst asserted mid-window: return to the reset state on the next edge. The partial window is discarded and no done pulse is produced.
- No error state: extra in_valid outside RUN is simply not accepted.

Test Plan:
- Reset, start, stream 256 samples with in_mag=100 and out_ready=1 -> 256 outputs, one per clk after 1-cycle latency; idx 0 gives wmag 0; idx 119 (weight 0xb) gives 1100>>4=68; idx 85 (weight 8) gives 50; out_last only at idx 255; done pulses once, 1 cycle after the last handshake.
- Saturation with OUT_W=12: in_mag=0xFFFF at idx 119 -> product 720885>>4=45055 -> out_wmag=0xFFF. With OUT_W=16, same stimulus -> 0xAFFF.
- Backpressure: hold out_ready=0 for 5 cycles at idx 37 -> in_ready=0, out_* stable with out_idx=37 and weight 4; on release, the stream resumes with no drop or duplication; output idx order stays contiguous 0..255.
- start pulsed at idx 50 mid-run -> ignored; idx continues to 51; the window completes normally with a single done.
- rst asserted at idx 120 -> next cycle all outputs at reset values, busy=0; a new start restarts at rom_addr=0.
- Random in_valid/out_ready toggling (50% each) over 3 back-to-back windows -> 768 outputs matching a reference model of weight[idx]*mag>>4; done count=3.

Source files
------------

// File: rtl/local_gau_weighter.sv
// Local Gaussian weighter: walks a 16x16 window, looks up the weight ROM
// and emits mag*weight, scaled and saturated, under valid/ready handshakes.
module local_gau_weighter #(
  parameter int MAG_W = 16,
  parameter int ORI_W = 3,
  parameter int OUT_W = 16,
  parameter int SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W-1:0] in_mag,
  input  logic [ORI_W-1:0] in_ori,
  output logic [7:0]       rom_addr,
  input  logic [7:0]       rom_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_wmag,
  output logic [ORI_W-1:0] out_ori,
  output logic [7:0]       out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int PW = MAG_W + 8;
  localparam logic [PW-1:0] MAXV =
    {{(PW-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t          state;
  logic [7:0]      idx;
  logic [PW-1:0]   prod;
  logic [PW-1:0]   scaled;
  logic [OUT_W-1:0] sat;
  logic            acc;
  logic            cons;

  // ROM is combinational, so the address is simply the index register
  assign rom_addr = idx;
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign acc      = in_valid && in_ready;
  assign cons     = out_valid && out_ready;

  assign prod   = {8'b0, in_mag} * {{MAG_W{1'b0}}, rom_data};
  assign scaled = prod >> SHIFT;
  assign sat    = (scaled > MAXV) ? {OUT_W{1'b1}}
                                  : scaled[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 8'd0;
      out_valid <= 1'b0;
      out_wmag  <= '0;
      out_ori   <= '0;
      out_idx   <= 8'd0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (acc) begin
        out_valid <= 1'b1;
        out_wmag  <= sat;
        out_ori   <= in_ori;
        out_idx   <= idx;
        out_last  <= (idx == 8'hff);
        idx       <= idx + 8'd1;
      end else if (cons) begin
        out_valid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            idx   <= 8'd0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (acc && idx == 8'hff) state <= DRAIN;
        end
        DRAIN: begin
          // output register holds sample 255 until it is taken
          if (cons) begin
            state <= IDLE;
            idx   <= 8'd0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_local_gau_weighter.sv
// Bench for local_gau_weighter: directed windows plus randomized
// handshakes, scored against a queue-based arithmetic reference.
module tb_local_gau_weighter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_mag;
  logic [2:0]  in_ori;
  logic [7:0]  rom_data, rom_data12;

  logic        in_ready, out_valid, out_last, busy, done;
  logic [7:0]  rom_addr, out_idx;
  logic [15:0] out_wmag;
  logic [2:0]  out_ori;

  logic        in_ready12, out_valid12, out_last12, busy12, done12;
  logic [7:0]  rom_addr12, out_idx12;
  logic [11:0] out_wmag12;
  logic [2:0]  out_ori12;

  logic [7:0] wtab [256];

  always #5 clk = ~clk;

  assign rom_data   = wtab[rom_addr];
  assign rom_data12 = wtab[rom_addr12];

  local_gau_weighter #(.OUT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mag(in_mag), .in_ori(in_ori),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wmag(out_wmag), .out_ori(out_ori),
    .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .done(done)
  );

  local_gau_weighter #(.OUT_W(12)) dut12 (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready12),
    .in_mag(in_mag), .in_ori(in_ori),
    .rom_addr(rom_addr12), .rom_data(rom_data12),
    .out_valid(out_valid12), .out_ready(out_ready),
    .out_wmag(out_wmag12), .out_ori(out_ori12),
    .out_idx(out_idx12), .out_last(out_last12),
    .busy(busy12), .done(done12)
  );

  typedef struct {
    int         idx;
    int         w16;
    int         w12;
    logic [2:0] ori;
    logic       last;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   acc_n;
  int   outs;
  int   dones = 0;
  int   cur_mode;
  bit   exp_done;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t model(input int k, input logic [15:0] m,
                                 input logic [2:0] o);
    exp_t e;
    int   s;
    s      = (int'(wtab[k]) * int'(m)) >> 4;
    e.idx  = k;
    e.w16  = (s > 65535) ? 65535 : s;
    e.w12  = (s > 4095) ? 4095 : s;
    e.ori  = o;
    e.last = (k == 255);
    return e;
  endfunction

  task automatic rst_chk(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_wmag"}, 32'(out_wmag), 0);
    chk({tag, "_out_ori"}, 32'(out_ori), 0);
    chk({tag, "_out_idx"}, 32'(out_idx), 0);
    chk({tag, "_out_last"}, 32'(out_last), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
  endtask

  // one clock: score handshakes seen this cycle, then advance
  task automatic tick();
    exp_t e;
    bit   nd;
    nd = 1'b0;
    #1;
    chk("done", 32'(done), 32'(exp_done));
    chk("mirror12",
        32'({out_ori12, out_last12, busy12, done12,
             out_valid12, in_ready12, out_idx12}),
        32'({out_ori, out_last, busy, done,
             out_valid, in_ready, out_idx}));
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("extra_out", 32'(out_valid), 0);
      end else begin
        e = q.pop_front();
        chk("idx", 32'(out_idx), e.idx);
        chk("wmag", 32'(out_wmag), e.w16);
        chk("wmag12", 32'(out_wmag12), e.w12);
        chk("ori", 32'(out_ori), 32'(e.ori));
        chk("last", 32'(out_last), 32'(e.last));
        if (cur_mode == 0 && e.idx == 119) chk("w119", 32'(out_wmag), 68);
        if (cur_mode == 0 && e.idx == 85) chk("w85", 32'(out_wmag), 50);
        if (cur_mode == 0 && e.idx == 0) chk("w0", 32'(out_wmag), 0);
        if (cur_mode == 1 && e.idx == 119) begin
          chk("sat12", 32'(out_wmag12), 'hfff);
          chk("nosat16", 32'(out_wmag), 'hafff);
        end
        nd = e.last;
        outs++;
      end
    end
    if (in_valid && in_ready) begin
      q.push_back(model(acc_n, in_mag, in_ori));
      acc_n++;
    end
    @(posedge clk);
    exp_done = nd;
    @(negedge clk);
    if (done) dones++;
  endtask

  task automatic run_window();
    int n;
    int bp;
    int d0;
    acc_n     = 0;
    outs      = 0;
    d0        = dones;
    start     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_run", 32'(busy), 1);
    chk("rom_addr0", 32'(rom_addr), 0);
    n  = 0;
    bp = 0;
    while (dones == d0 && n < 3000) begin
      in_valid  = (cur_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = (cur_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      in_mag    = (cur_mode == 0) ? 16'd100 :
                  (acc_n == 119) ? 16'hffff : 16'($urandom);
      in_ori    = 3'($urandom);
      start     = (cur_mode == 0 && acc_n == 50);
      if (cur_mode == 3 && acc_n == 120) begin
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        q.delete();
        exp_done = 1'b0;
        #1;
        rst_chk("midrst");
        break;
      end
      if (cur_mode == 1 && out_valid && q.size() > 0
          && q[0].idx == 37 && bp < 5) begin
        out_ready = 1'b0;
        bp++;
        #1;
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_out_valid", 32'(out_valid), 1);
        chk("bp_out_idx", 32'(out_idx), 37);
        chk("bp_out_wmag", 32'(out_wmag), q[0].w16);
      end
      tick();
      n++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (cur_mode != 3) begin
      chk("outs", 32'(outs), 256);
      chk("one_done", 32'(dones - d0), 1);
      chk("busy_idle", 32'(busy), 0);
      if (cur_mode == 0) chk("latency", 32'(n), 257);
      if (cur_mode == 1) chk("bp_cycles", 32'(bp), 5);
    end
  endtask

  initial begin
    int d;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        int d4;
        d4 = (2 * r - 15) * (2 * r - 15) + (2 * c - 15) * (2 * c - 15);
        wtab[r * 16 + c] = (d4 >= 400) ? 8'd0 : 8'(11 - d4 / 40);
      end
    end
    wtab[119] = 8'd11;
    wtab[85]  = 8'd8;
    wtab[37]  = 8'd4;

    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_mag    = 16'd0;
    in_ori    = 3'd0;
    exp_done  = 1'b0;
    q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    rst_chk("reset");
    rst = 1'b0;
    @(negedge clk);

    cur_mode = 0;
    run_window();
    cur_mode = 1;
    run_window();
    cur_mode = 3;
    run_window();
    cur_mode = 2;
    d = dones;
    repeat (3) run_window();
    chk("done3", 32'(dones - d), 3);

    in_valid = 1'b0;
    tick();
    tick();
    chk("end_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
